hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_stat_cnt.sv | 26 ++
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-address width and the load-use detection rule.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_W     = 8;
    localparam int FLUSH_W    = 3;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        BR_FLUSH = 2'b10
    } state_t;

    // A load in EX whose destination feeds an operand currently being decoded.
    // Register 0 is hard-wired, so a load into it never creates a dependency.
    function automatic logic load_use(
        input logic                  memread,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [REG_ADDR_W-1:0] id_rs1,
        input logic [REG_ADDR_W-1:0] id_rs2,
        input logic                  uses_rs2
    );
        return memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (uses_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/hazard_stat_cnt.sv
// 16-bit saturating event counter with enable and synchronous active-low reset.
module hazard_stat_cnt
    import hazard_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    output logic [STAT_W-1:0] cnt_o
);

    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] r_cnt;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + STAT_ONE;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory
// wait freezes, with a sticky memory-timeout flag.
// Optional statistics counters (stall and flush cycle counts) are built when
// the macro HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
)
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs2_i,
    input  logic                  br_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  hazard_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  pipe_freeze_o,
    output logic                  timeout_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cnt_o,
    output logic [STAT_W-1:0]     flush_cnt_o
`endif
);

    localparam logic [FLUSH_W-1:0] FLUSH_INIT  = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE    = WAIT_W'(1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE   = FLUSH_W'(1);

    state_t               r_state;
    state_t               r_ret_state;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic                 r_timeout;

    state_t               w_state_nxt;
    state_t               w_ret_nxt;
    state_t               w_eff_state;
    logic [FLUSH_W-1:0]   w_flush_nxt;
    logic [WAIT_W-1:0]    w_wait_nxt;
    logic                 w_timeout_nxt;
    logic                 w_mem_stall;
    logic                 w_load_use;

    assign w_mem_stall = mem_req_i & ~mem_ack_i;
    assign w_load_use  = load_use(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);

    // State, counters and the sticky timeout flag; reset abandons any
    // in-progress flush or memory wait.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state and output decode. The cycle in which a memory ack arrives is
    // decoded as the state we will return to, so the pipeline resumes without
    // losing a cycle. During flush cycles IF/ID stays write-enabled; the flush
    // clears it while the PC advances to the branch target.
    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret_state;
        w_flush_nxt   = r_flush_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout;

        hazard_o      = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        pipe_freeze_o = 1'b0;

        if ((r_state == MEM_WAIT) && mem_ack_i) begin
            w_eff_state = r_ret_state;
            w_wait_nxt  = '0;
        end else begin
            w_eff_state = r_state;
        end
        w_state_nxt = w_eff_state;

        case (w_eff_state)
            MEM_WAIT: begin
                pipe_freeze_o = 1'b1;
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                w_wait_nxt    = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_ONE;
                if (w_wait_nxt == TIMEOUT_VAL) begin
                    w_timeout_nxt = 1'b1;
                end
            end
            BR_FLUSH: begin
                if (w_mem_stall) begin
                    pipe_freeze_o = 1'b1;
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    w_ret_nxt     = BR_FLUSH;
                    w_state_nxt   = MEM_WAIT;
                end else begin
                    hazard_o     = 1'b1;
                    ifid_flush_o = 1'b1;
                    w_flush_nxt  = (r_flush_cnt == '0) ? '0 : r_flush_cnt - FLUSH_ONE;
                    w_state_nxt  = (w_flush_nxt == '0) ? RUN : BR_FLUSH;
                end
            end
            default: begin
                if (w_mem_stall) begin
                    pipe_freeze_o = 1'b1;
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    w_ret_nxt     = RUN;
                    w_state_nxt   = MEM_WAIT;
                end else if (br_taken_i) begin
                    hazard_o     = 1'b1;
                    ifid_flush_o = 1'b1;
                    w_flush_nxt  = FLUSH_INIT;
                    w_state_nxt  = (FLUSH_INIT != '0) ? BR_FLUSH : RUN;
                end else if (w_load_use) begin
                    hazard_o     = 1'b1;
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                end
            end
        endcase

        if (!rst_n_i) begin
            hazard_o      = 1'b1;
            ifid_flush_o  = 1'b1;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b0;
        end
    end

    assign timeout_o = r_timeout;

`ifdef HAZARD_STATS_EN
    logic w_stall_en;
    assign w_stall_en = ~pc_write_o;

    hazard_stat_cnt u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_stall_en),
        .cnt_o   (stall_cnt_o)
    );

    hazard_stat_cnt u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (ifid_flush_o),
        .cnt_o   (flush_cnt_o)
    );
`endif

endmodule
